// File: rtl/sonar_pkg.sv
// Shared definitions for the multi-channel ultrasonic sonar scanner.
// Holds the controller state encoding and the compile-time helpers that
// turn microsecond timings and the speed of sound into clock-cycle units.
package sonar_pkg;

  // Half the speed of sound in mm/s (343.21 m/s / 2 for the round trip).
  localparam longint SOUND_MM_PER_S_HALF = 171_605;
  // Fractional bits of the distance accumulator.
  localparam int     FRAC_BITS           = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_REPORT,
    S_HOLDOFF
  } state_e;

  // Microseconds to clock cycles; freq is a whole number of MHz.
  function automatic longint us_to_cyc(input longint freq, input longint us);
    return (freq / 1_000_000) * us;
  endfunction

  // Q16 millimetres travelled (one way) per clock cycle, rounded.
  function automatic longint inc_q16(input longint freq);
    return (SOUND_MM_PER_S_HALF * (longint'(1) << FRAC_BITS) + freq / 2) / freq;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Per-channel two-flop synchroniser for the asynchronous echo lines, with
// single-cycle rise/fall flags derived from the synchronised level.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   echo_i   raw echo lines, one per sensor
//   sync_o   synchronised echo levels
//   rise_o   synchronised level went 0 -> 1 this cycle
//   fall_o   synchronised level went 1 -> 0 this cycle
module sonar_echo_sync #(
  parameter int CHANNELS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] echo_i,
  output logic [CHANNELS-1:0] sync_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  logic [CHANNELS-1:0] meta_q;
  logic [CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_scanner.sv
// Multi-channel HC-SR04 style sonar controller. Pings the enabled sensors
// one at a time in ascending channel order, measures each echo pulse as a
// millimetre distance, and enforces an idle holdoff after every result to
// keep one sensor's ping from being heard by the next.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a sweep (only looked at while idle)
//   continuous        chain sweeps back to back while ch_mask is non-zero
//   ch_mask           enabled channels, latched at each sweep start
//   echo              asynchronous echo lines
//   trig              trigger lines, at most one high
//   busy              controller not idle
//   dist_valid        one-cycle result strobe
//   dist_ch/dist_mm/dist_timeout  result fields, held until the next result
//   sweep_done        one-cycle strobe once the last channel's holdoff ends
module sonar_scanner
  import sonar_pkg::*;
#(
  parameter int FREQ            = 50_000_000,
  parameter int CHANNELS        = 4,
  parameter int DIST_W          = 16,
  parameter int TRIG_US         = 10,
  parameter int ECHO_TIMEOUT_US = 25_000,
  parameter int HOLDOFF_US      = 60_000,
  localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trig,
  output logic                busy,
  output logic                dist_valid,
  output logic [CH_W-1:0]     dist_ch,
  output logic [DIST_W-1:0]   dist_mm,
  output logic                dist_timeout,
  output logic                sweep_done
);

  localparam longint TRIG_CYC = us_to_cyc(FREQ, TRIG_US);
  localparam longint TO_CYC   = us_to_cyc(FREQ, ECHO_TIMEOUT_US);
  localparam longint HOLD_CYC = us_to_cyc(FREQ, HOLDOFF_US);
  localparam longint CNT_MAX  = (TRIG_CYC > HOLD_CYC) ? TRIG_CYC : HOLD_CYC;
  localparam int     CNT_W    = $clog2(CNT_MAX + 1);
  localparam int     TMO_W    = $clog2(TO_CYC + 1);
  localparam int     ACC_W    = DIST_W + FRAC_BITS;

  localparam logic [ACC_W-1:0]  INC       = ACC_W'(inc_q16(FREQ));
  localparam logic [CNT_W-1:0]  TRIG_LOAD = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]  TO_LOAD   = TMO_W'(TO_CYC);
  // All-ones is reserved for the timeout code, so valid results stop one short.
  localparam logic [DIST_W-1:0] DIST_MAX  = {{(DIST_W-1){1'b1}}, 1'b0};

  function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
    lowest_set = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, INC};
    sat_add = s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // Integer millimetres; only an all-ones integer part can exceed DIST_MAX.
  function automatic logic [DIST_W-1:0] to_mm(input logic [ACC_W-1:0] a);
    logic [DIST_W-1:0] ip;
    ip = a[ACC_W-1:FRAC_BITS];
    to_mm = (ip == '1) ? DIST_MAX : ip;
  endfunction

  logic [CHANNELS-1:0] echo_sync, echo_rise, echo_fall;

  sonar_echo_sync #(
    .CHANNELS (CHANNELS)
  ) u_echo_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .echo_i (echo),
    .sync_o (echo_sync),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                armed_q, armed_d;
  logic                rep_d, rep_to_d, done_d;
  logic [CHANNELS-1:0] trig_d;
  logic                has_next;
  logic [CH_W-1:0]     next_ch;

  logic [CHANNELS-1:0] trig_q;
  logic                busy_q, dist_valid_q, dist_timeout_q, sweep_done_q;
  logic [CH_W-1:0]     dist_ch_q;
  logic [DIST_W-1:0]   dist_mm_q;

  // Next enabled channel above the current one in the latched mask.
  always_comb begin
    has_next = 1'b0;
    next_ch  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    acc_d    = acc_q;
    armed_d  = armed_q;
    rep_d    = 1'b0;
    rep_to_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          ch_d    = lowest_set(ch_mask);
          cnt_d   = TRIG_LOAD;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (cnt_q == '0) begin
          tmo_d   = TO_LOAD;
          acc_d   = '0;
          armed_d = 1'b0;
          state_d = S_WAIT_ECHO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_ECHO: begin
        // A rise only counts once the line has been seen low in this state,
        // so an echo that is already high on entry is ignored until it drops.
        if (tmo_q == '0) begin
          rep_d    = 1'b1;
          rep_to_d = 1'b1;
          state_d  = S_REPORT;
        end else begin
          tmo_d = tmo_q - 1'b1;
          if (!echo_sync[ch_q]) armed_d = 1'b1;
          if (armed_q && echo_rise[ch_q]) begin
            acc_d   = INC;
            state_d = S_MEASURE;
          end
        end
      end
      S_MEASURE: begin
        // Echo end wins over a timeout expiring in the same cycle.
        if (echo_fall[ch_q]) begin
          rep_d   = 1'b1;
          state_d = S_REPORT;
        end else if (tmo_q == '0) begin
          rep_d    = 1'b1;
          rep_to_d = 1'b1;
          state_d  = S_REPORT;
        end else begin
          tmo_d = tmo_q - 1'b1;
          acc_d = sat_add(acc_q);
        end
      end
      S_REPORT: begin
        cnt_d   = HOLD_LOAD;
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (has_next) begin
          ch_d    = next_ch;
          cnt_d   = TRIG_LOAD;
          state_d = S_TRIG;
        end else begin
          done_d = 1'b1;
          if (continuous && (ch_mask != '0)) begin
            mask_d  = ch_mask;
            ch_d    = lowest_set(ch_mask);
            cnt_d   = TRIG_LOAD;
            state_d = S_TRIG;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    trig_d = '0;
    if (state_d == S_TRIG) trig_d[ch_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      ch_q           <= '0;
      cnt_q          <= '0;
      tmo_q          <= '0;
      acc_q          <= '0;
      armed_q        <= 1'b0;
      trig_q         <= '0;
      busy_q         <= 1'b0;
      dist_valid_q   <= 1'b0;
      dist_ch_q      <= '0;
      dist_mm_q      <= '0;
      dist_timeout_q <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      acc_q        <= acc_d;
      armed_q      <= armed_d;
      trig_q       <= trig_d;
      busy_q       <= (state_d != S_IDLE);
      dist_valid_q <= rep_d;
      sweep_done_q <= done_d;
      if (rep_d) begin
        dist_ch_q      <= ch_q;
        dist_mm_q      <= rep_to_d ? '1 : to_mm(acc_q);
        dist_timeout_q <= rep_to_d;
      end
    end
  end

  assign trig         = trig_q;
  assign busy         = busy_q;
  assign dist_valid   = dist_valid_q;
  assign dist_ch      = dist_ch_q;
  assign dist_mm      = dist_mm_q;
  assign dist_timeout = dist_timeout_q;
  assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_sonar_scanner.sv
// Bench for sonar_scanner: behavioural sensors answer each trigger with an
// echo pulse of a chosen length; results are compared to distances computed
// from the pulse length and the speed of sound.
module tb_sonar_scanner;

  localparam int     FREQ     = 1_000_000;
  localparam int     TRIG_US  = 10;
  localparam int     TO_US    = 2000;
  localparam int     HOLD_US  = 100;
  localparam int     TRIG_CYC = TRIG_US * (FREQ / 1_000_000);
  localparam int     HOLD_CYC = HOLD_US * (FREQ / 1_000_000);
  localparam longint INC_M    = (171_605 * longint'(65536) + FREQ / 2) / FREQ;
  localparam int     ECHO_DLY = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [3:0]  ch_mask = 4'b0000;
  logic [3:0]  echo = 4'b0000;
  logic [3:0]  trig;
  logic        busy, dist_valid, dist_timeout, sweep_done;
  logic [1:0]  dist_ch;
  logic [15:0] dist_mm;

  sonar_scanner #(
    .FREQ            (FREQ),
    .CHANNELS        (4),
    .DIST_W          (16),
    .TRIG_US         (TRIG_US),
    .ECHO_TIMEOUT_US (TO_US),
    .HOLDOFF_US      (HOLD_US)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .ch_mask      (ch_mask),
    .echo         (echo),
    .trig         (trig),
    .busy         (busy),
    .dist_valid   (dist_valid),
    .dist_ch      (dist_ch),
    .dist_mm      (dist_mm),
    .dist_timeout (dist_timeout),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor configuration: echo length per channel (0 = silent), stuck-high
  // lines and lines carrying random noise.
  int         lens[4];
  logic [3:0] stuck = 4'b0000;
  logic [3:0] noise = 4'b0000;

  // Observation records.
  int rq_ch[$], rq_mm[$], rq_to[$], rq_cyc[$];
  int ts_ch[$], ts_cyc[$], tw[$], tf_cyc[$];
  int n_done = 0, done_cyc = 0, busy_cnt = 0, overlap = 0;
  logic [3:0] tprev = 4'b0000;
  int tw_cnt[4];
  int dly[4];
  int rem[4];

  initial begin
    for (int c = 0; c < 4; c++) begin
      lens[c] = 0; tw_cnt[c] = 0; dly[c] = 0; rem[c] = 0;
    end
  end

  // Monitor plus sensor models, all away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e;
    if (dist_valid) begin
      rq_ch.push_back(int'(dist_ch));
      rq_mm.push_back(int'(dist_mm));
      rq_to.push_back(int'(dist_timeout));
      rq_cyc.push_back(cyc);
    end
    if (sweep_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if ($countones(trig) > 1) overlap <= overlap + 1;
    e = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (trig[c] && !tprev[c]) begin
        ts_ch.push_back(c);
        ts_cyc.push_back(cyc);
        tw_cnt[c] <= 1;
      end else if (trig[c]) begin
        tw_cnt[c] <= tw_cnt[c] + 1;
      end
      if (!trig[c] && tprev[c]) begin
        tw.push_back(tw_cnt[c]);
        tf_cyc.push_back(cyc);
      end
      e[c] = (rem[c] > 0) | stuck[c] | (noise[c] & ($urandom_range(0, 1) == 1));
      if (tprev[c] && !trig[c] && lens[c] > 0) dly[c] <= ECHO_DLY;
      else if (rem[c] > 0) rem[c] <= rem[c] - 1;
      else if (dly[c] > 1) dly[c] <= dly[c] - 1;
      else if (dly[c] == 1) begin
        dly[c] <= 0;
        rem[c] <= lens[c];
      end
    end
    tprev <= trig;
    echo  <= e;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected distance: one-way path at 171.605 mm/ms, in Q16 per cycle.
  function automatic int exp_mm(input int c);
    longint v;
    if (stuck[c] || lens[c] == 0) return 65535;
    v = (longint'(lens[c]) * INC_M) >> 16;
    return (v > 65534) ? 65534 : int'(v);
  endfunction

  task automatic pulse_start(output int sc);
    @(negedge clk);
    start = 1'b1;
    sc    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget, input string tag);
    int n;
    n = 0;
    while (n_done == db && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_done == db) check({tag, ":wait_done"}, 0, 1);
  endtask

  task automatic run_sweep(input logic [3:0] m, input string tag, input bit poke);
    int rb, tb0, wb, fb, db, ob, sc, dum, k, dt;
    rb = rq_ch.size(); tb0 = ts_ch.size(); wb = tw.size(); fb = tf_cyc.size();
    db = n_done; ob = overlap;
    ch_mask = m;
    pulse_start(sc);
    if (poke) begin
      repeat (200) @(negedge clk);
      ch_mask = 4'b1111;
      pulse_start(dum);
      ch_mask = m;
    end
    wait_done(db, 12000, tag);
    repeat (3) @(negedge clk);
    check({tag, ":n_done"}, n_done - db, 1);
    check({tag, ":busy_end"}, busy, 0);
    check({tag, ":overlap"}, overlap - ob, 0);
    check({tag, ":n_rep"}, rq_ch.size() - rb, $countones(m));
    check({tag, ":n_trig"}, tw.size() - wb, $countones(m));
    if (ts_cyc.size() > tb0) check({tag, ":trig_lat"}, ts_cyc[tb0] - sc, 1);
    k = 0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        if (rb + k < rq_ch.size()) begin
          check({tag, ":ch"}, rq_ch[rb + k], c);
          check({tag, ":mm"}, rq_mm[rb + k], exp_mm(c));
          check({tag, ":to"}, rq_to[rb + k], (exp_mm(c) == 65535) ? 1 : 0);
          if (exp_mm(c) == 65535 && fb + k < tf_cyc.size()) begin
            dt = rq_cyc[rb + k] - tf_cyc[fb + k];
            check({tag, ":to_time"}, (dt >= TO_US - 5 && dt <= TO_US + 10) ? 1 : 0, 1);
          end
        end
        if (tb0 + k < ts_ch.size()) check({tag, ":trig_ch"}, ts_ch[tb0 + k], c);
        if (wb + k < tw.size()) check({tag, ":trig_w"}, tw[wb + k], TRIG_CYC);
        k++;
      end
    end
    if (rq_cyc.size() > rb)
      check({tag, ":done_gap"}, done_cyc - rq_cyc[rq_cyc.size() - 1], HOLD_CYC + 1);
  endtask

  initial begin
    int rb, tb0, db, bc, sc, n, t1;
    logic [3:0] m;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:outs", {trig, busy, dist_valid, dist_ch, dist_mm, dist_timeout, sweep_done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel
    lens[1] = 1000;
    run_sweep(4'b0010, "single", 1'b0);

    // Silent sensor times out
    lens[0] = 0;
    run_sweep(4'b0001, "timeout", 1'b0);

    // Sweep order, channel 2 skipped, start while busy ignored
    lens[0] = 500; lens[1] = 1000; lens[2] = 700; lens[3] = 1500;
    run_sweep(4'b1011, "order", 1'b1);

    // Echo stuck high before the trigger
    @(negedge clk);
    stuck = 4'b0100;
    run_sweep(4'b0100, "stuck", 1'b0);
    stuck = 4'b0000;

    // Empty mask start
    bc = busy_cnt; db = n_done;
    ch_mask = 4'b0000;
    pulse_start(sc);
    repeat (20) @(negedge clk);
    check("mask0:busy", busy_cnt - bc, 0);
    check("mask0:done", n_done - db, 0);

    // Continuous mode, then stop by clearing the mask
    rb = rq_ch.size(); tb0 = ts_ch.size();
    lens[0] = 300;
    ch_mask = 4'b0001;
    continuous = 1'b1;
    pulse_start(sc);
    n = 0;
    while (rq_ch.size() < rb + 3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    ch_mask = 4'b0000;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("cont:idle", busy, 0);
    t1 = ts_ch.size();
    repeat (400) @(negedge clk);
    check("cont:no_trig", ts_ch.size() - t1, 0);
    continuous = 1'b0;
    check("cont:n_rep", (rq_ch.size() - rb >= 3) ? 1 : 0, 1);
    for (int k = 0; k < 3; k++) begin
      if (rb + k < rq_mm.size()) check("cont:mm", rq_mm[rb + k], exp_mm(0));
      if (k < 2 && tb0 + k + 1 < ts_cyc.size() && rb + k < rq_cyc.size())
        check("cont:spacing", ts_cyc[tb0 + k + 1] - rq_cyc[rb + k], HOLD_CYC + 1);
    end

    // Reset during MEASURE
    rb = rq_ch.size();
    lens[0] = 1000;
    ch_mask = 4'b0001;
    pulse_start(sc);
    repeat (TRIG_CYC + ECHO_DLY + 300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid:outs", {trig, busy, dist_valid, dist_ch, dist_mm, dist_timeout, sweep_done}, 0);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    check("rst_mid:no_rep", rq_ch.size() - rb, 0);
    check("rst_mid:idle", busy, 0);
    lens[1] = 1000;
    run_sweep(4'b0010, "post_rst", 1'b0);

    // Randomised sweeps with noise on disabled channels
    for (int it = 0; it < 5; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++)
        lens[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1800));
      @(negedge clk);
      noise = ~m;
      run_sweep(m, "rand", 1'b0);
      noise = 4'b0000;
      repeat (5) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
